// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: N-port round-robin arbiter in front of a single-ported synchronous memory
// with 1-cycle read latency. One port is granted per cycle, the other requesters see mem_busy,
// and a registered one-hot rvalid tells which port owns the memory read data in the next cycle.
// Optional build macro MEM_ARB_BURST_EN lets the last winner keep the grant for up to MAXBURST
// consecutive cycles while it keeps requesting.
module mem_arbiter_rr #(
  parameter int unsigned NPORTS    = 3,
  parameter int unsigned PORTW     = 32,
  parameter int unsigned ADDRWIDTH = 15,
  parameter int unsigned MAXBURST  = 4
) (
  input  logic                        clk,
  input  logic                        rstx,
  input  logic [NPORTS*PORTW-1:0]     d_in,
  input  logic [NPORTS*ADDRWIDTH-1:0] addr_in,
  input  logic [NPORTS-1:0]           en_in_x,
  input  logic [NPORTS-1:0]           wr_in_x,
  input  logic [NPORTS*PORTW-1:0]     bit_wr_in_x,
  output logic [PORTW-1:0]            d,
  output logic [ADDRWIDTH-1:0]        addr,
  output logic                        en_x,
  output logic                        wr_x,
  output logic [PORTW-1:0]            bit_wr_x,
  output logic [NPORTS-1:0]           mem_busy,
  output logic [NPORTS-1:0]           rvalid
);

  localparam int unsigned PtrW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  // Round-robin state
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic [NPORTS-1:0] rvalid_q, rvalid_d;

  // Request / winner
  logic [NPORTS-1:0] req;
  logic              grant;
  logic [PtrW-1:0]   win;
  logic [NPORTS-1:0] win_oh;
  logic              found_hi;
  logic [PtrW-1:0]   win_hi;
  logic              found_lo;
  logic [PtrW-1:0]   win_lo;

  // Selected port's fields
  logic [PtrW-1:0]      sel;
  logic [PORTW-1:0]     d_sel;
  logic [ADDRWIDTH-1:0] addr_sel;
  logic                 wr_sel;
  logic [PORTW-1:0]     bw_sel;

`ifdef MEM_ARB_BURST_EN
  logic [7:0]      hold_cnt_q, hold_cnt_d;
  logic [7:0]      cnt_bump;
  logic [PtrW-1:0] hold_port_q, hold_port_d;
  logic            hold_req;
  logic            hold_active;
`else
  // MAXBURST only matters when the hold logic is built in
  logic [31:0] unused_maxburst;
  assign unused_maxburst = MAXBURST;
`endif

  // While in reset the arbiter looks idle to the memory and to the requesters
  assign req = rstx ? ~en_in_x : '0;

`ifdef MEM_ARB_BURST_EN
  // Burst hold: does the current holder still request and has it grants left?
  always_comb begin
    hold_req = 1'b0;
    for (int i = 0; i < int'(NPORTS); i++) begin
      if (PtrW'(i) == hold_port_q) hold_req = req[i];
    end
    hold_active = hold_req && (hold_cnt_q != 8'd0) && (32'(hold_cnt_q) < MAXBURST);
  end
`endif

  // Winner: first requester at or above ptr, otherwise first requester from index 0
  always_comb begin
    found_hi = 1'b0;
    win_hi   = '0;
    found_lo = 1'b0;
    win_lo   = '0;
    for (int i = 0; i < int'(NPORTS); i++) begin
      if (!found_hi && req[i] && (PtrW'(i) >= ptr_q)) begin
        found_hi = 1'b1;
        win_hi   = PtrW'(i);
      end
    end
    for (int i = 0; i < int'(NPORTS); i++) begin
      if (!found_lo && req[i]) begin
        found_lo = 1'b1;
        win_lo   = PtrW'(i);
      end
    end
    grant = found_lo;
    win   = found_hi ? win_hi : win_lo;
`ifdef MEM_ARB_BURST_EN
    if (hold_active) win = hold_port_q;
`endif
  end

  // One-hot winner vector; all zero when nobody is granted
  always_comb begin
    win_oh = '0;
    for (int i = 0; i < int'(NPORTS); i++) begin
      win_oh[i] = grant && (PtrW'(i) == win);
    end
  end

  // Field mux: winner's fields on a grant, port ptr's fields when idle
  always_comb begin
    sel      = grant ? win : ptr_q;
    d_sel    = '0;
    addr_sel = '0;
    wr_sel   = 1'b1;
    bw_sel   = '1;
    for (int i = 0; i < int'(NPORTS); i++) begin
      if (PtrW'(i) == sel) begin
        d_sel    = d_in[i*PORTW +: PORTW];
        addr_sel = addr_in[i*ADDRWIDTH +: ADDRWIDTH];
        wr_sel   = wr_in_x[i];
        bw_sel   = bit_wr_in_x[i*PORTW +: PORTW];
      end
    end
  end

  // Memory-side and requester-side outputs
  always_comb begin
    d        = d_sel;
    addr     = addr_sel;
    en_x     = ~grant;
    wr_x     = grant ? wr_sel : 1'b1;
    bit_wr_x = grant ? bw_sel : '1;
    mem_busy = req & ~win_oh;
    rvalid   = rvalid_q;
  end

  // Next state: pointer past the winner, read strobe for the granted port
  always_comb begin
    ptr_d = ptr_q;
    if (grant) begin
      ptr_d = (32'(win) == NPORTS - 1) ? '0 : win + 1'b1;
    end
    rvalid_d = (grant && wr_sel) ? win_oh : '0;
`ifdef MEM_ARB_BURST_EN
    // Count consecutive grants to the same port; zero means no hold in progress
    cnt_bump    = ((hold_cnt_q != 8'd0) && (win == hold_port_q)) ? hold_cnt_q + 8'd1 : 8'd1;
    hold_port_d = grant ? win : hold_port_q;
    if (!grant || (32'(cnt_bump) >= MAXBURST)) begin
      hold_cnt_d = 8'd0;
    end else begin
      hold_cnt_d = cnt_bump;
    end
`endif
  end

  // State registers
  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      ptr_q       <= '0;
      rvalid_q    <= '0;
`ifdef MEM_ARB_BURST_EN
      hold_cnt_q  <= 8'd0;
      hold_port_q <= '0;
`endif
    end else begin
      ptr_q       <= ptr_d;
      rvalid_q    <= rvalid_d;
`ifdef MEM_ARB_BURST_EN
      hold_cnt_q  <= hold_cnt_d;
      hold_port_q <= hold_port_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr (NPORTS=3): table-driven vectors with an rvalid scoreboard queue,
// plus a hand-written reset-during-read sequence.
module tb_mem_arbiter_rr;

  localparam int NP = 3;
  localparam int PW = 32;
  localparam int AW = 15;

  logic             clk = 1'b0;
  logic             rstx;
  logic [NP*PW-1:0] d_in;
  logic [NP*AW-1:0] addr_in;
  logic [NP-1:0]    en_in_x;
  logic [NP-1:0]    wr_in_x;
  logic [NP*PW-1:0] bit_wr_in_x;
  logic [PW-1:0]    d;
  logic [AW-1:0]    addr;
  logic             en_x;
  logic             wr_x;
  logic [PW-1:0]    bit_wr_x;
  logic [NP-1:0]    mem_busy;
  logic [NP-1:0]    rvalid;

  mem_arbiter_rr #(
    .NPORTS   (NP),
    .PORTW    (PW),
    .ADDRWIDTH(AW),
    .MAXBURST (4)
  ) dut (
    .clk        (clk),
    .rstx       (rstx),
    .d_in       (d_in),
    .addr_in    (addr_in),
    .en_in_x    (en_in_x),
    .wr_in_x    (wr_in_x),
    .bit_wr_in_x(bit_wr_in_x),
    .d          (d),
    .addr       (addr),
    .en_x       (en_x),
    .wr_x       (wr_x),
    .bit_wr_x   (bit_wr_x),
    .mem_busy   (mem_busy),
    .rvalid     (rvalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  en;    // en_in_x
    logic [2:0]  wr;    // wr_in_x
    logic [14:0] a1;    // port 1 address
    int          win;   // expected winner, -1 = idle
    logic [2:0]  busy;  // expected mem_busy
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [2:0] rv_q[$];

  logic [14:0] port_a[3];
  logic [31:0] port_d[3];
  logic [31:0] port_bw[3];

  vec_t main_tbl[20];
  vec_t b1_tbl[10];
  vec_t b2_tbl[7];

  function automatic vec_t mk(logic [2:0] en, logic [2:0] wr, logic [14:0] a1, int win,
                              logic [2:0] busy);
    vec_t v;
    v.en   = en;
    v.wr   = wr;
    v.a1   = a1;
    v.win  = win;
    v.busy = busy;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] en, input logic [2:0] wr, input logic [14:0] a1);
    port_a[0]  = 15'h10;
    port_a[1]  = a1;
    port_a[2]  = 15'h30;
    port_d[0]  = 32'h1111_1111;
    port_d[1]  = 32'hDEAD_BEEF;
    port_d[2]  = 32'h3333_3333;
    port_bw[0] = wr[0] ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    port_bw[1] = wr[1] ? 32'hFFFF_FFFF : 32'h0000_0000;
    port_bw[2] = wr[2] ? 32'hFFFF_FFFF : 32'hFF00_FF00;
    en_in_x     = en;
    wr_in_x     = wr;
    addr_in     = {port_a[2], port_a[1], port_a[0]};
    d_in        = {port_d[2], port_d[1], port_d[0]};
    bit_wr_in_x = {port_bw[2], port_bw[1], port_bw[0]};
  endtask

  // One cycle: drive after the edge, check combinational outputs and last cycle's rvalid
  task automatic run_vec(input vec_t v, input string tag);
    logic [2:0] exp_rv;
    @(posedge clk);
    #1;
    drive(v.en, v.wr, v.a1);
    @(negedge clk);
    if (rv_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s scoreboard: queue empty, expected an entry", tag);
    end else begin
      exp_rv = rv_q.pop_front();
      check({tag, " rvalid"}, 64'(rvalid), 64'(exp_rv));
    end
    check({tag, " mem_busy"}, 64'(mem_busy), 64'(v.busy));
    if (v.win < 0) begin
      check({tag, " en_x"}, 64'(en_x), 64'(1'b1));
      check({tag, " wr_x"}, 64'(wr_x), 64'(1'b1));
      check({tag, " bit_wr_x"}, 64'(bit_wr_x), 64'(32'hFFFF_FFFF));
      rv_q.push_back(3'b000);
    end else begin
      check({tag, " en_x"}, 64'(en_x), 64'(1'b0));
      check({tag, " wr_x"}, 64'(wr_x), 64'(v.wr[v.win]));
      check({tag, " addr"}, 64'(addr), 64'(port_a[v.win]));
      check({tag, " d"}, 64'(d), 64'(port_d[v.win]));
      check({tag, " bit_wr_x"}, 64'(bit_wr_x), 64'(port_bw[v.win]));
      rv_q.push_back(v.wr[v.win] ? 3'(1 << v.win) : 3'b000);
    end
  endtask

  task automatic do_reset();
    rstx = 1'b0;
    drive(3'b111, 3'b111, 15'h20);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset rvalid", 64'(rvalid), 64'(3'b000));
    check("reset en_x", 64'(en_x), 64'(1'b1));
    check("reset mem_busy", 64'(mem_busy), 64'(3'b000));
    rstx = 1'b1;
    rv_q.delete();
    rv_q.push_back(3'b000);
  endtask

  initial begin
    // Round-robin table, starting from reset (ptr=0)
    for (int i = 0; i < 5; i++) main_tbl[i] = mk(3'b111, 3'b111, 15'h20, -1, 3'b000);
    for (int i = 0; i < 6; i++) begin
      main_tbl[5+i] = mk(3'b000, 3'b111, 15'h20, i % 3,
                         (i % 3 == 0) ? 3'b110 : (i % 3 == 1) ? 3'b101 : 3'b011);
    end
    main_tbl[11] = mk(3'b101, 3'b101, 15'h05, 1, 3'b000);  // port 1 write alone, ptr->2
    main_tbl[12] = mk(3'b010, 3'b111, 15'h20, 2, 3'b001);  // wrap: 2 wins first
    main_tbl[13] = mk(3'b010, 3'b111, 15'h20, 0, 3'b100);  // then 0
    main_tbl[14] = mk(3'b110, 3'b111, 15'h20, 0, 3'b000);  // single requester
    main_tbl[15] = mk(3'b110, 3'b111, 15'h20, 0, 3'b000);
    main_tbl[16] = mk(3'b001, 3'b101, 15'h20, 1, 3'b100);  // port 1 write beats 2
    main_tbl[17] = mk(3'b001, 3'b101, 15'h20, 2, 3'b010);
    main_tbl[18] = mk(3'b011, 3'b011, 15'h20, 2, 3'b000);  // port 2 write alone
    main_tbl[19] = mk(3'b111, 3'b111, 15'h20, -1, 3'b000);

    // Burst tables (MAXBURST=4), each from reset
    for (int i = 0; i < 9; i++) begin
      b1_tbl[i] = mk(3'b100, 3'b111, 15'h20, (i >= 4 && i < 8) ? 1 : 0,
                     (i >= 4 && i < 8) ? 3'b001 : 3'b010);
    end
    b1_tbl[9] = mk(3'b111, 3'b111, 15'h20, -1, 3'b000);
    b2_tbl[0] = mk(3'b100, 3'b111, 15'h20, 0, 3'b010);
    b2_tbl[1] = mk(3'b100, 3'b111, 15'h20, 0, 3'b010);
    for (int i = 2; i < 6; i++) b2_tbl[i] = mk(3'b101, 3'b111, 15'h20, 1, 3'b000);
    b2_tbl[6] = mk(3'b111, 3'b111, 15'h20, -1, 3'b000);

    do_reset();
`ifdef MEM_ARB_BURST_EN
    foreach (b1_tbl[i]) run_vec(b1_tbl[i], $sformatf("burst1[%0d]", i));
    do_reset();
    foreach (b2_tbl[i]) run_vec(b2_tbl[i], $sformatf("burst2[%0d]", i));
`else
    foreach (main_tbl[i]) run_vec(main_tbl[i], $sformatf("rr[%0d]", i));
`endif

    // Reset while a port 1 read is returning; next grant must restart from port 0
    do_reset();
    @(posedge clk);
    #1;
    drive(3'b101, 3'b111, 15'h20);
    @(posedge clk);
    #1;
    check("midrst rvalid before", 64'(rvalid), 64'(3'b010));
    drive(3'b000, 3'b111, 15'h20);
    #1;
    rstx = 1'b0;
    #1;
    check("midrst rvalid cleared", 64'(rvalid), 64'(3'b000));
    check("midrst en_x idle", 64'(en_x), 64'(1'b1));
    check("midrst mem_busy idle", 64'(mem_busy), 64'(3'b000));
    @(negedge clk);
    rstx = 1'b1;
    #1;
    check("postrst en_x", 64'(en_x), 64'(1'b0));
    check("postrst addr", 64'(addr), 64'(15'h10));
    check("postrst mem_busy", 64'(mem_busy), 64'(3'b110));
    @(posedge clk);
    #1;
    check("postrst rvalid", 64'(rvalid), 64'(3'b001));
    drive(3'b111, 3'b111, 15'h20);
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
